// File: rtl/seven_seg_capture.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_capture
//  Description : Samples a time-multiplexed active-low seven-segment bus,
//                qualifies each digit for stability, decodes segment patterns
//                back to hex nibbles and presents whole words on a one-entry
//                valid/ready output with overrun indication.
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   digit_sel_n,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NUM_DIGITS-1:0] out_value,
    output logic [NUM_DIGITS-1:0]   out_err,
    output logic                    overrun
);

    localparam int                    CW          = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]         C_STABLE    = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]         C_STABLE_M1 = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]         C_ONE       = CW'(1);
    localparam logic [NUM_DIGITS-1:0] C_ALL_SET   = '1;

    // True when exactly one select line is driven low.
    function automatic logic onehot_low(input logic [NUM_DIGITS-1:0] sel_n);
        int zeros;
        zeros = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!sel_n[i]) zeros++;
        end
        return (zeros == 1);
    endfunction

    // Returns {err, nibble}; unknown patterns decode to nibble 0 with err set.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b1000000: r = 5'h00;
            7'b1111001: r = 5'h01;
            7'b0100100: r = 5'h02;
            7'b0110000: r = 5'h03;
            7'b0011001: r = 5'h04;
            7'b0010010: r = 5'h05;
            7'b0000010: r = 5'h06;
            7'b1111000: r = 5'h07;
            7'b0000000: r = 5'h08;
            7'b0010000: r = 5'h09;
            7'b0001000: r = 5'h0A;
            7'b0000011: r = 5'h0B;
            7'b1000110: r = 5'h0C;
            7'b0100001: r = 5'h0D;
            7'b0000110: r = 5'h0E;
            7'b0001110: r = 5'h0F;
            default:    r = 5'h10;
        endcase
        return r;
    endfunction

    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    hit_q, hit_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [4*NUM_DIGITS-1:0] slot_val_q, slot_val_d;
    logic [NUM_DIGITS-1:0]   slot_err_q, slot_err_d;
    logic                    out_valid_q, out_valid_d;
    logic [4*NUM_DIGITS-1:0] out_value_q, out_value_d;
    logic [NUM_DIGITS-1:0]   out_err_q, out_err_d;
    logic                    overrun_q, overrun_d;
    logic [4:0]              w_dec;
    logic                    w_frame_done;

    assign w_dec        = decode(seg_q);
    assign w_frame_done = (mask_q == C_ALL_SET);

    // Input registering and stability tracking. The counter describes the pair
    // being registered this edge, so it reaches STABLE_CYCLES right after the
    // last qualifying edge; hit marks the single cycle a run first qualifies.
    always_comb begin
        seg_d = seg_in;
        sel_d = digit_sel_n;
        cnt_d = cnt_q;
        hit_d = 1'b0;
        if (!onehot_low(digit_sel_n)) begin
            cnt_d = '0;
        end else if ({seg_in, digit_sel_n} != {seg_q, sel_q}) begin
            cnt_d = C_ONE;
            hit_d = (STABLE_CYCLES == 1);
        end else if (cnt_q != C_STABLE) begin
            cnt_d = cnt_q + C_ONE;
            hit_d = (cnt_q == C_STABLE_M1);
        end
    end

    // Frame assembly and output handshake. A frame completing while the
    // output is still held (and not being accepted) is dropped with overrun.
    always_comb begin
        mask_d      = mask_q;
        slot_val_d  = slot_val_q;
        slot_err_d  = slot_err_q;
        out_valid_d = out_valid_q;
        out_value_d = out_value_q;
        out_err_d   = out_err_q;
        overrun_d   = 1'b0;
        if (w_frame_done) begin
            mask_d = '0;
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                out_value_d = slot_val_q;
                out_err_d   = slot_err_q;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        // A capture in the completion cycle belongs to the next frame.
        if (hit_q) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (!sel_q[i]) begin
                    slot_val_d[4*i +: 4] = w_dec[3:0];
                    slot_err_d[i]        = w_dec[4];
                    mask_d[i]            = 1'b1;
                end
            end
        end
    end

    // Input stage and stability state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= '1;
            sel_q <= '1;
            cnt_q <= '0;
            hit_q <= 1'b0;
        end else begin
            seg_q <= seg_d;
            sel_q <= sel_d;
            cnt_q <= cnt_d;
            hit_q <= hit_d;
        end
    end

    // Slot storage and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q      <= '0;
            slot_val_q  <= '0;
            slot_err_q  <= '0;
            out_valid_q <= 1'b0;
            out_value_q <= '0;
            out_err_q   <= '0;
            overrun_q   <= 1'b0;
        end else begin
            mask_q      <= mask_d;
            slot_val_q  <= slot_val_d;
            slot_err_q  <= slot_err_d;
            out_valid_q <= out_valid_d;
            out_value_q <= out_value_d;
            out_err_q   <= out_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_value = out_value_q;
    assign out_err   = out_err_q;
    assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg_capture
//  Description : Self-checking bench for seven_seg_capture: directed scans
//                plus randomized digit runs against a frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  digit_sel_n;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_value;
    logic [3:0]  out_err;
    logic        overrun;

    int total  = 0;
    int passed = 0;
    int ovr_cnt = 0;
    int ovr_snap;
    bit sb_on = 1'b0;
    int pushed = 0;
    int seen   = 0;
    logic [19:0] exp_q[$];

    seven_seg_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .digit_sel_n (digit_sel_n),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_value   (out_value),
        .out_err     (out_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Active-low segment encoding of a hex nibble.
    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // Reverse lookup through the encoding table: {err, nibble}.
    function automatic logic [4:0] model_decode(input logic [6:0] p);
        for (int k = 0; k < 16; k++) begin
            if (enc(4'(k)) == p) return {1'b0, 4'(k)};
        end
        return 5'h10;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] p, input logic [3:0] s, input int n);
        seg_in      = p;
        digit_sel_n = s;
        repeat (n) tick();
    endtask

    task automatic scan(input logic [15:0] w);
        logic [3:0] s;
        for (int d = 0; d < 4; d++) begin
            s    = 4'hF;
            s[d] = 1'b0;
            drive(enc(w[4*d +: 4]), s, 3);
        end
    endtask

    task automatic blank_wait2();
        seg_in      = 7'h7F;
        digit_sel_n = 4'hF;
        tick();
        tick();
    endtask

    // Frame-level model state for the randomized phase.
    logic [3:0] m_val [4];
    logic [3:0] m_err;
    logic [3:0] m_mask;

    task automatic model_capture(input int idx, input logic [6:0] p);
        logic [4:0] d;
        d           = model_decode(p);
        m_val[idx]  = d[3:0];
        m_err[idx]  = d[4];
        m_mask[idx] = 1'b1;
        if (m_mask == 4'hF) begin
            exp_q.push_back({m_err, m_val[3], m_val[2], m_val[1], m_val[0]});
            pushed++;
            m_mask = 4'h0;
        end
    endtask

    always @(negedge clk) begin
        if (overrun === 1'b1) ovr_cnt++;
    end

    always @(negedge clk) begin
        logic [19:0] e;
        if (sb_on && rst_n && out_valid && out_ready) begin
            seen++;
            check("sb_queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_value", 64'(out_value), 64'(e[15:0]));
                check("sb_err", 64'(out_err), 64'(e[19:16]));
            end
        end
    end

    initial begin
        logic [6:0] p, prev_p;
        logic [3:0] s, prev_s;
        int kind, len, i1, i2;

        rst_n       = 1'b0;
        seg_in      = 7'h7F;
        digit_sel_n = 4'hF;
        out_ready   = 1'b1;
        repeat (3) tick();
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_value", 64'(out_value), 64'd0);
        check("reset_err", 64'(out_err), 64'd0);
        check("reset_overrun", 64'(overrun), 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic scan with exact latency.
        ovr_snap = ovr_cnt;
        scan(16'h3A7F);
        seg_in      = 7'h7F;
        digit_sel_n = 4'hF;
        check("scan_valid_e3", 64'(out_valid), 64'd0);
        tick();
        check("scan_valid_e4", 64'(out_valid), 64'd0);
        tick();
        check("scan_valid_e5", 64'(out_valid), 64'd1);
        check("scan_value", 64'(out_value), 64'h3A7F);
        check("scan_err", 64'(out_err), 64'd0);
        tick();
        check("scan_accept", 64'(out_valid), 64'd0);
        check("scan_overrun", 64'(ovr_cnt - ovr_snap), 64'd0);

        // Glitch rejection: digit1 only 2 cycles.
        out_ready = 1'b0;
        drive(enc(4'h6), 4'b1110, 3);
        drive(enc(4'h9), 4'b1101, 2);
        drive(enc(4'hC), 4'b1011, 3);
        drive(enc(4'h5), 4'b0111, 3);
        blank_wait2();
        tick();
        tick();
        check("glitch_no_frame", 64'(out_valid), 64'd0);
        drive(enc(4'h9), 4'b1101, 3);
        seg_in      = 7'h7F;
        digit_sel_n = 4'hF;
        tick();
        check("glitch_valid_e4", 64'(out_valid), 64'd0);
        tick();
        check("glitch_valid_e5", 64'(out_valid), 64'd1);
        check("glitch_value", 64'(out_value), 64'h5C96);
        out_ready = 1'b1;
        tick();
        check("glitch_accept", 64'(out_valid), 64'd0);

        // Non-hex pattern on digit2.
        drive(enc(4'h1), 4'b1110, 3);
        drive(enc(4'h2), 4'b1101, 3);
        drive(7'h7F,     4'b1011, 3);
        drive(enc(4'h4), 4'b0111, 3);
        blank_wait2();
        check("invalid_valid", 64'(out_valid), 64'd1);
        check("invalid_value", 64'(out_value), 64'h4021);
        check("invalid_err", 64'(out_err), 64'b0100);
        tick();

        // Backpressure: second frame dropped with a single overrun pulse.
        out_ready = 1'b0;
        scan(16'h1234);
        blank_wait2();
        check("bp_first_valid", 64'(out_valid), 64'd1);
        check("bp_first_value", 64'(out_value), 64'h1234);
        ovr_snap = ovr_cnt;
        scan(16'h5678);
        blank_wait2();
        tick();
        check("bp_overrun_once", 64'(ovr_cnt - ovr_snap), 64'd1);
        check("bp_held_value", 64'(out_value), 64'h1234);
        check("bp_held_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release", 64'(out_valid), 64'd0);

        // Accept and load in the same cycle.
        scan(16'h1111);
        blank_wait2();
        check("sim_first_value", 64'(out_value), 64'h1111);
        ovr_snap = ovr_cnt;
        scan(16'h2222);
        seg_in      = 7'h7F;
        digit_sel_n = 4'hF;
        tick();
        check("sim_hold_value", 64'(out_value), 64'h1111);
        out_ready = 1'b1;
        tick();
        check("sim_valid", 64'(out_valid), 64'd1);
        check("sim_value", 64'(out_value), 64'h2222);
        tick();
        check("sim_no_overrun", 64'(ovr_cnt - ovr_snap), 64'd0);
        check("sim_accept", 64'(out_valid), 64'd0);

        // Reset mid-frame.
        drive(enc(4'h5), 4'b1110, 3);
        drive(enc(4'h6), 4'b1101, 3);
        seg_in      = 7'h7F;
        digit_sel_n = 4'hF;
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_value", 64'(out_value), 64'd0);
        check("midrst_valid", 64'(out_valid), 64'd0);
        tick();
        check("midrst_err", 64'(out_err), 64'd0);
        rst_n = 1'b1;
        tick();
        scan(16'hBEEF);
        blank_wait2();
        check("midrst_word_valid", 64'(out_valid), 64'd1);
        check("midrst_word", 64'(out_value), 64'hBEEF);
        check("midrst_word_err", 64'(out_err), 64'd0);
        tick();

        // Randomized runs against the frame-level model.
        m_mask   = 4'h0;
        m_err    = 4'h0;
        for (int k = 0; k < 4; k++) m_val[k] = 4'h0;
        ovr_snap = ovr_cnt;
        prev_p   = 7'h7F;
        prev_s   = 4'hF;
        out_ready = 1'b1;
        sb_on    = 1'b1;
        for (int r = 0; r < 150; r++) begin
            kind = int'($urandom_range(0, 99));
            len  = int'($urandom_range(1, 5));
            s    = 4'hF;
            if (kind < 70) begin
                i1    = int'($urandom_range(0, 3));
                s[i1] = 1'b0;
                if ($urandom_range(0, 4) == 0) p = 7'($urandom);
                else p = enc(4'($urandom_range(0, 15)));
            end else if (kind < 85) begin
                p = 7'($urandom);
            end else begin
                i1 = int'($urandom_range(0, 3));
                i2 = (i1 + int'($urandom_range(1, 3))) % 4;
                s[i1] = 1'b0;
                s[i2] = 1'b0;
                p = enc(4'($urandom_range(0, 15)));
            end
            if ({p, s} == {prev_p, prev_s}) drive(7'h7F, 4'hF, 1);
            drive(p, s, len);
            if (kind < 70 && len >= 3) model_capture(i1, p);
            prev_p = p;
            prev_s = s;
        end
        drive(7'h7F, 4'hF, 8);
        sb_on = 1'b0;
        check("rand_all_frames_seen", 64'(seen), 64'(pushed));
        check("rand_queue_drained", 64'(exp_q.size()), 64'd0);
        check("rand_no_overrun", 64'(ovr_cnt - ovr_snap), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
